// File: rtl/sphn_btn_conditioner_if.sv
// Button-conditioner bus: raw paddle buttons in, debounced/resolved levels and press pulses out.
// The master side belongs to the pad ring and game logic; the slave side is the conditioner.
interface sphn_btn_conditioner_if;
    logic i_btn_up;
    logic i_btn_down;
    logic o_move_up;
    logic o_move_down;
    logic o_up_press;
    logic o_down_press;

    modport master (
        output i_btn_up,
        output i_btn_down,
        input  o_move_up,
        input  o_move_down,
        input  o_up_press,
        input  o_down_press
    );

    modport slave (
        input  i_btn_up,
        input  i_btn_down,
        output o_move_up,
        output o_move_down,
        output o_up_press,
        output o_down_press
    );
endinterface

// File: rtl/sphn_btn_conditioner.sv
// Paddle button conditioner: 2-flop synchronizer, per-button debounce FSM and opposing-press resolver.
// Optional macro SPHN_LAST_WINS_EN: when both buttons are held, the most recently pressed one wins.
module sphn_btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                         pix_clk,
    input  logic                         pix_rst_n,
    sphn_btn_conditioner_if.slave        btn
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int CH_UP = 0;
    localparam int CH_DN = 1;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } dbnc_state_e;

    logic [1:0] btn_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] held;
    logic [1:0] press_pulse_q;
    logic       move_up_c;
    logic       move_dn_c;

    assign btn_raw = {btn.i_btn_down, btn.i_btn_up};

    // Plain two-flop synchronizer; nothing may sit between the stages.
    always_ff @(posedge pix_clk or negedge pix_rst_n) begin
        if (!pix_rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef SPHN_LAST_WINS_EN
    logic [1:0] held_entry;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            dbnc_state_e      state_q;
            dbnc_state_e      state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             press_q;
            logic             press_d;
            logic             held_c;
            logic             smp;

            assign smp = sync2_q[gi];

            always_ff @(posedge pix_clk or negedge pix_rst_n) begin
                if (!pix_rst_n) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    press_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                end
            end

            // Counter is cleared on every state entry and stops at CNT_LAST, so it never wraps.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                unique case (state_q)
                    ST_IDLE: begin
                        if (smp) begin
                            state_d = ST_PRESS_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!smp) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = ST_HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    ST_HELD: begin
                        if (!smp) begin
                            state_d = ST_RELEASE_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (smp) begin
                            state_d = ST_HELD;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            // A bounce that returns to HELD from RELEASE_WAIT is not a new press.
            always_comb begin
                held_c  = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
                press_d = (state_q == ST_PRESS_WAIT) && (state_d == ST_HELD);
            end

            assign held[gi]          = held_c;
            assign press_pulse_q[gi] = press_q;
`ifdef SPHN_LAST_WINS_EN
            assign held_entry[gi]    = press_d;
`endif
        end
    endgenerate

`ifdef SPHN_LAST_WINS_EN
    // last_dir_q: 0 = up, 1 = down; up takes priority on simultaneous entry.
    logic last_dir_q;
    logic last_dir_d;

    always_comb begin
        last_dir_d = last_dir_q;
        if (held_entry[CH_UP]) begin
            last_dir_d = 1'b0;
        end else if (held_entry[CH_DN]) begin
            last_dir_d = 1'b1;
        end
    end

    always_ff @(posedge pix_clk or negedge pix_rst_n) begin
        if (!pix_rst_n) begin
            last_dir_q <= 1'b0;
        end else begin
            last_dir_q <= last_dir_d;
        end
    end

    always_comb begin
        move_up_c = held[CH_UP] & ~held[CH_DN];
        move_dn_c = held[CH_DN] & ~held[CH_UP];
        if (held[CH_UP] && held[CH_DN]) begin
            move_up_c = ~last_dir_q;
            move_dn_c = last_dir_q;
        end
    end
`else
    always_comb begin
        move_up_c = held[CH_UP] & ~held[CH_DN];
        move_dn_c = held[CH_DN] & ~held[CH_UP];
    end
`endif

    assign btn.o_move_up    = move_up_c;
    assign btn.o_move_down  = move_dn_c;
    assign btn.o_up_press   = press_pulse_q[CH_UP];
    assign btn.o_down_press = press_pulse_q[CH_DN];

endmodule
